// File: rtl/match_session_ctrl.sv
// Session controller for the UART pattern detector: arms a session, gates the receiver,
// counts matches/frames and raises a level IRQ. Optional timeout guarded by MATCH_TIMEOUT_EN.
module match_session_ctrl #(
  parameter int CNT_W        = 8,
  parameter int FRM_W        = 8,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             bit_strobe,
  input  logic             match,
  input  logic             frame_done,
  input  logic             framing_error,
  input  logic             irq_ack,
  output logic             rx_enable,
  output logic [3:0]       pattern,
  output logic [CNT_W-1:0] match_count,
  output logic [FRM_W-1:0] frame_count,
  output logic             irq,
  output logic [1:0]       err_code,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_ERR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] match_inc;
  logic [1:0]       err_nx;
  logic             ld_cfg;
  logic             inc_match;
  logic             inc_frame;
  logic             timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [FRM_W-1:0] sat_inc_frm(input logic [FRM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign match_inc = sat_inc_cnt(match_count);

`ifdef MATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_BITS + 1);
  logic [TMR_W-1:0] tmr;

  // Timeout fires on the strobe that would bring the count to TIMEOUT_BITS.
  assign timeout_hit = bit_strobe && (tmr == TMR_W'(TIMEOUT_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst)
      tmr <= '0;
    else if (ld_cfg || inc_match)
      tmr <= '0;
    else if (state == S_RUN && bit_strobe && !abort)
      tmr <= tmr + 1'b1;
  end
`else
  localparam int unused_timeout_bits = TIMEOUT_BITS;
  logic unused_bit_strobe;
  assign unused_bit_strobe = bit_strobe;
  assign timeout_hit       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // abort outranks every other request; error outranks match in RUN.
  always_comb begin
    state_nx  = state;
    err_nx    = err_code;
    ld_cfg    = 1'b0;
    inc_match = 1'b0;
    inc_frame = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      if (state == S_ARM || state == S_RUN)
        err_nx = 2'd3;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nx = S_ARM;
            ld_cfg   = 1'b1;
            err_nx   = 2'd0;
          end
        end
        S_ARM:  state_nx = S_RUN;
        S_RUN: begin
          inc_frame = frame_done;
          if (framing_error) begin
            state_nx = S_ERR;
            err_nx   = 2'd1;
          end else if (match) begin
            inc_match = 1'b1;
            if (match_inc == target)
              state_nx = S_DONE;
          end else if (timeout_hit) begin
            state_nx = S_ERR;
            err_nx   = 2'd2;
          end
        end
        S_DONE, S_ERR: begin
          if (irq_ack)
            state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern     <= '0;
      target      <= '0;
      match_count <= '0;
      frame_count <= '0;
      err_code    <= 2'd0;
    end else begin
      err_code <= err_nx;
      if (ld_cfg) begin
        pattern     <= cfg_pattern;
        target      <= (cfg_target == '0) ? CNT_W'(1) : cfg_target;
        match_count <= '0;
        frame_count <= '0;
      end else begin
        if (inc_match)
          match_count <= match_inc;
        if (inc_frame)
          frame_count <= sat_inc_frm(frame_count);
      end
    end
  end

  assign rx_enable = (state == S_RUN);
  assign irq       = (state == S_DONE) || (state == S_ERR);
  assign busy      = (state == S_ARM) || (state == S_RUN);

endmodule
